// File: rtl/fadd_arb_pkg.sv
// Shared types and constants for the FP adder arbiter.
package fadd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int NUM_FLAGS   = 4;
  localparam int FLAG_NAN    = 3;
  localparam int FLAG_OVF    = 2;
  localparam int FLAG_UDF    = 1;
  localparam int FLAG_ZERO   = 0;

  // Adder pipeline depth after start; done is visible ADD_LATENCY+1 cycles after start.
  localparam int ADD_LATENCY = 6;

endpackage

// File: rtl/fadd_rr_arbiter.sv
// Request selector: fixed lowest-index priority, or round-robin from ptr_i
// when FADD_ARB_RR_EN is defined.
module fadd_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
`ifdef FADD_ARB_RR_EN
  input  logic [ID_WIDTH-1:0] ptr_i,
`endif
  input  logic [NUM_REQ-1:0]  req_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                any_o
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef FADD_ARB_RR_EN
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
`else
      j = k;
`endif
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = ID_WIDTH'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one start/done FP adder among NUM_REQ requesters, one operation at a time.
// Define FADD_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module fadd_arbiter
  import fadd_arb_pkg::*;
#(
  parameter int FLOAT_WIDTH = 64,
  parameter int NUM_REQ     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_op_sub,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op2,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [FLOAT_WIDTH-1:0]         rsp_data,
  output logic [NUM_FLAGS-1:0]           rsp_flags,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     owner_id,
  output logic                           add_start,
  output logic                           add_op_sub,
  output logic [FLOAT_WIDTH-1:0]         add_op1,
  output logic [FLOAT_WIDTH-1:0]         add_op2,
  input  logic [FLOAT_WIDTH-1:0]         add_out,
  input  logic                           add_nan,
  input  logic                           add_overflow,
  input  logic                           add_underflow,
  input  logic                           add_zero,
  input  logic                           add_done
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_WIDTH-1:0]    win_idx, owner_q;
  logic                   win_any, accept;
  logic [FLOAT_WIDTH-1:0] op1_q, op2_q, rsp_data_q;
  logic                   op_sub_q;
  logic [NUM_FLAGS-1:0]   rsp_flags_q;

  assign accept = (state_q == IDLE) && win_any;

`ifdef FADD_ARB_RR_EN
  logic [ID_WIDTH-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_q <= '0;
    else if (accept) ptr_q <= (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + ID_WIDTH'(1);
  end
`endif

  fadd_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
`ifdef FADD_ARB_RR_EN
    .ptr_i (ptr_q),
`endif
    .req_i (req_valid),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (add_done) state_d = RESP;
      RESP:    if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    add_start = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        req_ready = gnt;
      end
      ISSUE:   add_start = 1'b1;
      RESP:    rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  // Operands only change on accept, so the adder sees them stable until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q    <= '0;
      op2_q    <= '0;
      op_sub_q <= 1'b0;
      owner_q  <= '0;
    end else if (accept) begin
      op1_q    <= req_op1[int'(win_idx)*FLOAT_WIDTH +: FLOAT_WIDTH];
      op2_q    <= req_op2[int'(win_idx)*FLOAT_WIDTH +: FLOAT_WIDTH];
      op_sub_q <= req_op_sub[win_idx];
      owner_q  <= win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else if (state_q == WAIT && add_done) begin
      rsp_data_q            <= add_out;
      rsp_flags_q[FLAG_NAN] <= add_nan;
      rsp_flags_q[FLAG_OVF] <= add_overflow;
      rsp_flags_q[FLAG_UDF] <= add_underflow;
      rsp_flags_q[FLAG_ZERO] <= add_zero;
    end
  end

  assign add_op1    = op1_q;
  assign add_op2    = op2_q;
  assign add_op_sub = op_sub_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign owner_id   = owner_q;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: behavioural adder, per-cycle protocol model, directed and random ops.
module tb_fadd_arbiter;
  import fadd_arb_pkg::*;

  localparam int FW = 64;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready, req_op_sub = '0;
  logic [N*FW-1:0] req_op1 = '0, req_op2 = '0;
  logic [N-1:0]    rsp_valid, rsp_ready = '1;
  logic [FW-1:0]   rsp_data;
  logic [3:0]      rsp_flags;
  logic            busy, add_start, add_op_sub;
  logic [IW-1:0]   owner_id;
  logic [FW-1:0]   add_op1, add_op2, add_out = '0;
  logic            add_nan = 1'b0, add_overflow = 1'b0, add_underflow = 1'b0, add_zero = 1'b0;
  logic            add_done = 1'b0;

  always #5 clk = ~clk;

  fadd_arbiter #(.FLOAT_WIDTH(FW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op_sub(req_op_sub),
    .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .busy(busy), .owner_id(owner_id),
    .add_start(add_start), .add_op_sub(add_op_sub), .add_op1(add_op1), .add_op2(add_op2),
    .add_out(add_out), .add_nan(add_nan), .add_overflow(add_overflow),
    .add_underflow(add_underflow), .add_zero(add_zero), .add_done(add_done)
  );

  // IEEE double add/sub from real arithmetic; flags {nan, ovf, udf, zero}.
  function automatic logic [67:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic sub);
    real        r;
    logic [63:0] d;
    logic [3:0]  f;
    r = sub ? ($bitstoreal(a) - $bitstoreal(b)) : ($bitstoreal(a) + $bitstoreal(b));
    d = $realtobits(r);
    f = 4'b0;
    if (d[62:52] == 11'h7FF && d[51:0] != 52'd0) begin
      d = 64'hFFF8000000000000;
      f[FLAG_NAN] = 1'b1;
    end else if (d[62:52] == 11'h7FF) f[FLAG_OVF] = 1'b1;
    else if (d[62:0] == 63'd0)        f[FLAG_ZERO] = 1'b1;
    else if (d[62:52] == 11'd0)       f[FLAG_UDF] = 1'b1;
    return {f, d};
  endfunction

  // Sequenced adder: done visible ADD_LATENCY+1 cycles after start, held until next start.
  int          am_cnt = 0;
  logic [67:0] am_res = '0;
  always @(posedge clk) begin
    if (add_start) begin
      am_cnt   <= 1;
      add_done <= 1'b0;
      am_res   <= ref_add(add_op1, add_op2, add_op_sub);
    end else if (am_cnt != 0) begin
      if (am_cnt == ADD_LATENCY) begin
        am_cnt   <= 0;
        add_done <= 1'b1;
        {add_nan, add_overflow, add_underflow, add_zero, add_out} <= am_res;
      end else am_cnt <= am_cnt + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          nchk = 0, nfail = 0;
  bit          tb_busy = 1'b0, rand_bp = 1'b0;
  int          acc_cyc = 0, own = 0, ptr = 0, bp_left = 0, resp_cnt = 0;
  int          first_start = -1, first_rsp = -1;
  int          rem[N];
  int          glog[$];
  logic [63:0] e_op1 = '0, e_op2 = '0, last_data = '0;
  logic        e_sub = 1'b0;
  logic [67:0] e_res = '0;
  logic [3:0]  last_flags = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int rem_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i];
    return s;
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom % 8)
      0:       return 64'h7FEFFFFFFFFFFFFF;
      1:       return 64'h0010000000000000;
      2:       return 64'h0010000000000001;
      default: return $realtobits(($itor($urandom_range(0, 2000)) - 1000.0) / 8.0);
    endcase
  endfunction

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic s);
    req_op1[i*FW +: FW] = a;
    req_op2[i*FW +: FW] = b;
    req_op_sub[i]       = s;
  endtask

  task automatic arm(input int i, input int n);
    rem[i] = n;
    set_op(i, rand_op(), rand_op(), 1'($urandom));
    req_valid[i] = (n > 0);
  endtask

  task automatic drive_rsp_ready();
    rsp_ready = N'($urandom);
    if (tb_busy) rsp_ready[own] = (bp_left > 0) ? 1'b0 : (rand_bp ? 1'($urandom) : 1'b1);
  endtask

  // Runs until every armed op has been answered; abort_after>0 returns at that WAIT cycle.
  task automatic run(input int budget, input int abort_after);
    int  t0, w, cc;
    bit  rexp, con;
    t0 = cyc;
    drive_rsp_ready();
    while (tb_busy || rem_total() != 0) begin
      if (cyc - t0 >= budget) begin
        nchk++;
        nfail++;
        $display("FAIL timeout: no completion within %0d cycles", budget);
        return;
      end
      @(negedge clk);
      cc   = cyc;
      w    = tb_busy ? -1 : winner(req_valid, ptr);
      rexp = tb_busy && (cc >= acc_cyc + 9);
      chk("req_ready", 64'(req_ready), 64'(onehot(w)));
      chk("busy", 64'(busy), 64'(tb_busy));
      chk("add_start", 64'(add_start), 64'(tb_busy && cc == acc_cyc + 1));
      chk("rsp_valid", 64'(rsp_valid), rexp ? 64'(onehot(own)) : 64'd0);
      if (tb_busy) begin
        chk("owner_id", 64'(owner_id), 64'(own));
        chk("add_op1", add_op1, e_op1);
        chk("add_op2", add_op2, e_op2);
        chk("add_op_sub", 64'(add_op_sub), 64'(e_sub));
        if (add_start && first_start < 0) first_start = cc - acc_cyc;
        if (rsp_valid != '0 && first_rsp < 0) first_rsp = cc - acc_cyc;
      end
      if (rexp) begin
        chk("rsp_data", rsp_data, e_res[63:0]);
        chk("rsp_flags", 64'(rsp_flags), 64'(e_res[67:64]));
        last_data  = rsp_data;
        last_flags = rsp_flags;
        resp_cnt++;
      end
      if (abort_after > 0 && tb_busy && cc == acc_cyc + abort_after) return;
      con = rexp && rsp_ready[own];
      @(posedge clk);
      #1;
      if (rexp && bp_left > 0) bp_left--;
      if (con) tb_busy = 1'b0;
      if (w >= 0) begin
        tb_busy = 1'b1;
        acc_cyc = cc;
        own     = w;
        e_op1   = req_op1[w*FW +: FW];
        e_op2   = req_op2[w*FW +: FW];
        e_sub   = req_op_sub[w];
        e_res   = ref_add(e_op1, e_op2, e_sub);
`ifdef FADD_ARB_RR_EN
        ptr = (w + 1) % N;
`endif
        glog.push_back(w);
        rem[w]--;
        arm(w, rem[w]);
      end
      drive_rsp_ready();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) rem[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_start", 64'(add_start), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    chk("rst_owner", 64'(owner_id), 64'd0);
    chk("rst_op1", add_op1, 64'd0);
    chk("rst_op2", add_op2, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency: 1.0 + 2.0 from requester 0
    arm(0, 1);
    set_op(0, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0);
    first_start = -1;
    first_rsp   = -1;
    run(100, 0);
    chk("lat_start", 64'(first_start), 64'd1);
    chk("lat_rsp", 64'(first_rsp), 64'd9);
    chk("lat_data", last_data, 64'h4008000000000000);
    chk("lat_flags", 64'(last_flags), 64'd0);

    // Special values: +inf - +inf from requester 3
    arm(3, 1);
    set_op(3, 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1);
    run(100, 0);
    chk("inf_data", last_data, 64'hFFF8000000000000);
    chk("inf_flags", 64'(last_flags), 64'h8);

    // Contention: all four at once
    glog.delete();
    for (int i = 0; i < N; i++) arm(i, 1);
    run(200, 0);
    chk("cont_n", 64'(glog.size()), 64'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("cont_order", 64'(glog[i]), 64'(i));

    // Requester 0 re-requests against requester 1
    glog.delete();
    arm(0, 3);
    arm(1, 1);
    run(200, 0);
    chk("rereq_n", 64'(glog.size()), 64'd4);
    if (glog.size() == 4) begin
`ifdef FADD_ARB_RR_EN
      chk("rereq_g1", 64'(glog[1]), 64'd1);
      chk("rereq_g3", 64'(glog[3]), 64'd0);
`else
      chk("rereq_g1", 64'(glog[1]), 64'd0);
      chk("rereq_g3", 64'(glog[3]), 64'd1);
`endif
    end

    // Backpressure: 5 low cycles on the first response while another request waits
    resp_cnt = 0;
    bp_left  = 5;
    arm(2, 1);
    arm(0, 1);
    run(200, 0);
    chk("bp_resp_cycles", 64'(resp_cnt), 64'd7);

    // Reset during WAIT
    arm(1, 1);
    run(100, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_start", 64'(add_start), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rsp_data", rsp_data, 64'd0);
    chk("mid_rst_flags", 64'(rsp_flags), 64'd0);
    chk("mid_rst_owner", 64'(owner_id), 64'd0);
    chk("mid_rst_op1", add_op1, 64'd0);
    chk("mid_rst_op2", add_op2, 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    tb_busy = 1'b0;
    ptr     = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
    end
    @(posedge clk);
    #1;
    glog.delete();
    arm(3, 1);
    arm(0, 1);
    run(200, 0);
    chk("post_rst_first", glog.size() > 0 ? 64'(glog[0]) : 64'hFFFF, 64'd0);

    // Random traffic with random response backpressure
    rand_bp = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) arm(i, $urandom_range(0, 2));
      run(rem_total() * 60 + 60, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/fadd_arbiter.md
# fadd_arbiter

Shares one multi-cycle floating-point adder (start/done, 7-stage sequenced unit) among NUM_REQ requesters. It accepts one operation at a time, holds the operands and op_sub stable for the adder's whole run, issues a one-cycle start, and waits for done. It then returns the result and status flags to the requester that owns the operation. It sits between the compute clients and the single adder instance in the FP datapath.

## Interface
- FLOAT_WIDTH, 64, operand width (64 or 32).
- NUM_REQ, 4, number of requesters (2..8); ID_WIDTH = clog2(NUM_REQ) is a derived localparam.
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_op_sub  in  NUM_REQ  per-requester subtract select.
- req_op1, req_op2  in  NUM_REQ*FLOAT_WIDTH  flattened operands; slice i belongs to requester i.
- rsp_valid  out  NUM_REQ  result valid, to owner only (one-hot or zero).
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  FLOAT_WIDTH  shared result bus.
- rsp_flags  out  4  {nan, overflow, underflow, zero}.
- busy  out  1  operation in flight (not IDLE).
- owner_id  out  ID_WIDTH  index of the current owner.
- add_start  out  1  adder start pulse.
- add_op_sub  out  1  subtract select to the adder.
- add_op1, add_op2  out  FLOAT_WIDTH  operands to the adder.
- add_out  in  FLOAT_WIDTH  adder result.
- add_nan, add_overflow, add_underflow, add_zero  in  1  adder flags.
- add_done  in  1  adder done; stays high until the next start.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbiter picks a winner among req_valid and drives req_ready[winner]=1 combinationally.
  - On valid&ready, latch op1/op2/op_sub and the owner id, then go to ISSUE.
  - A requester holds valid and its data stable until it sees ready.
- ISSUE: add_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - add_done is ignored outside WAIT.
  - The first WAIT cycle always sees done=0, because the adder's stage resets on start.
  - On add_done=1, capture add_out and the flags into response registers, then go to RESP.
- RESP:
  - rsp_valid[owner]=1, with rsp_data and rsp_flags held stable.
  - On rsp_ready[owner], go to IDLE.
  - No new request is accepted during ISSUE, WAIT or RESP.
- add_op1, add_op2 and add_op_sub are driven from the latched registers continuously from ISSUE through RESP. The adder reads sign and op_sub in late stages, so these must not change mid-operation.
- Flags are passed through unmodified; at most one is set.
- rsp_valid bits other than owner, and rsp_ready bits other than owner, are ignored.
- Reset values: state IDLE, RR pointer 0, owner_id 0, busy 0, add_start 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_flags 0, latched operands 0.
- Reset mid-operation: the in-flight operation is dropped and no response is sent. The adder resynchronises on the next add_start.

## Timing
- Accept in cycle T.
- add_start in T+1.
- add_done is first seen in T+8.
- rsp_valid from T+9.
- With rsp_ready held high, the next accept is possible at T+10, so peak throughput is one operation per 10 cycles.
- rsp_valid stays asserted indefinitely under backpressure.
- A requester whose valid drops before acceptance is simply not granted; this is legal.

## Configuration
- FADD_ARB_RR_EN defined: round-robin arbitration. The pointer moves to winner+1 (mod NUM_REQ) on each acceptance, and the search starts at the pointer.
- FADD_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register.

## Structure
- Package fadd_arb_pkg holds:
  - the state enum;
  - flag bit positions NAN=3, OVF=2, UDF=1, ZERO=0;
  - the ADD_LATENCY=6 constant used by the bench.
- Sub-module fadd_rr_arbiter: request vector plus pointer in, one-hot grant plus index out. It contains the priority/RR selection controlled by FADD_ARB_RR_EN.

## Test plan
- Latency: req 0 issues 1.0+2.0 (3FF0000000000000 + 4000000000000000) -> add_start at T+1, rsp_valid[0] at T+9, rsp_data 4008000000000000, flags 0000.
- Contention: all four requesters valid at once with RR enabled -> grants in order 0,1,2,3. With the macro off and requester 0 re-requesting, it is granted every time.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid, rsp_data and the flags are stable, and req_ready stays 0 throughout.
- Special values: +inf (7FF0000000000000) with op_sub=1 and op2=+inf -> rsp_data FFF8000000000000, flags 1000.
- Reset: rst_n pulsed low during WAIT -> all outputs at reset values immediately and no rsp_valid. A subsequent request then completes with a correct result.
- Operand stability: requester changes its req_op1 slice after acceptance -> add_op1 is unchanged until RESP exits.
